// File: rtl/wb_write_arbiter_pkg.sv
// Shared register-bus widths, write-enable encodings and the arbiter defaults.
package wb_write_arbiter_pkg;
  localparam int REG_BUS_W      = 32;
  localparam int REG_ADDR_W     = 5;
  localparam int MUL_FIFO_DEPTH = 2;
  localparam int STARVE_THRESH  = 4;

  localparam logic WRITE_ENABLE  = 1'b1;
  localparam logic WRITE_DISABLE = 1'b0;
  localparam logic [REG_BUS_W-1:0]  ZERO_WORD = '0;
  localparam logic [REG_ADDR_W-1:0] ZERO_ADDR = '0;

  typedef logic [REG_BUS_W-1:0]  reg_bus_t;
  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
endpackage

// File: rtl/wb_result_fifo.sv
// Sync FIFO for late multiply results; exposes every slot so the top can do forwarding lookups.
module wb_result_fifo
  import wb_write_arbiter_pkg::*;
#(
  parameter int DATA_W = REG_BUS_W,
  parameter int ADDR_W = REG_ADDR_W,
  parameter int DEPTH  = MUL_FIFO_DEPTH,
  localparam int PW    = $clog2(DEPTH)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          push,
  input  logic [ADDR_W-1:0]             push_addr,
  input  logic [DATA_W-1:0]             push_data,
  input  logic                          pop,
  output logic                          full,
  output logic                          empty,
  output logic [ADDR_W-1:0]             head_addr,
  output logic [DATA_W-1:0]             head_data,
  output logic [PW-1:0]                 rd_ptr,
  output logic [DEPTH-1:0]              ent_vld,
  output logic [DEPTH-1:0][ADDR_W-1:0]  ent_addr,
  output logic [DEPTH-1:0][DATA_W-1:0]  ent_data
);
  logic [PW-1:0] wr_ptr;
  logic [PW:0]   count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count   <= '0;
      ent_vld <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
      // pop and push never target the same slot: push needs !full, pop needs !empty
      if (pop)  ent_vld[rd_ptr] <= 1'b0;
      if (push) ent_vld[wr_ptr] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      ent_addr[wr_ptr] <= push_addr;
      ent_data[wr_ptr] <= push_data;
    end
  end

  assign full      = (count == (PW+1)'(DEPTH));
  assign empty     = (count == '0);
  assign head_addr = ent_addr[rd_ptr];
  assign head_data = ent_data[rd_ptr];
endmodule

// File: rtl/wb_write_arbiter.sv
// Single regfile write port shared by the MEM/WB pipe (priority) and buffered multiply results.
module wb_write_arbiter
  import wb_write_arbiter_pkg::*;
#(
  parameter int DATA_W     = REG_BUS_W,
  parameter int ADDR_W     = REG_ADDR_W,
  parameter int DEPTH      = MUL_FIFO_DEPTH,
  parameter int STARVE_MAX = STARVE_THRESH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pipe_we,
  input  logic [ADDR_W-1:0] pipe_waddr,
  input  logic [DATA_W-1:0] pipe_wdata,
  input  logic              mul_valid,
  input  logic [ADDR_W-1:0] mul_waddr,
  input  logic [DATA_W-1:0] mul_wdata,
  output logic              mul_ready,
  output logic              we,
  output logic [ADDR_W-1:0] waddr,
  output logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] lk_addr1,
  output logic              lk_hit1,
  output logic [DATA_W-1:0] lk_data1,
  input  logic [ADDR_W-1:0] lk_addr2,
  output logic              lk_hit2,
  output logic [DATA_W-1:0] lk_data2,
  output logic              stallreq
);
  localparam int PW = $clog2(DEPTH);
  localparam int SW = $clog2(STARVE_MAX + 1);

  logic                         full, empty, push, pop, pipe_act;
  logic [ADDR_W-1:0]            head_addr;
  logic [DATA_W-1:0]            head_data;
  logic [PW-1:0]                rd_ptr, idx;
  logic [DEPTH-1:0]             ent_vld;
  logic [DEPTH-1:0][ADDR_W-1:0] ent_addr;
  logic [DEPTH-1:0][DATA_W-1:0] ent_data;
  logic [SW-1:0]                starve;
  logic [1:0][ADDR_W-1:0]       lk_addr_v;
  logic [1:0]                   lk_hit_v;
  logic [1:0][DATA_W-1:0]       lk_data_v;

  assign pipe_act  = pipe_we && (pipe_waddr != '0);
  assign mul_ready = rst && !full;
  // address-0 results complete the handshake but are dropped
  assign push      = mul_valid && mul_ready && (mul_waddr != '0);
  assign pop       = rst && !pipe_act && !empty;

  wb_result_fifo #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_fifo (
    .clk(clk), .rst(rst), .push(push), .push_addr(mul_waddr), .push_data(mul_wdata),
    .pop(pop), .full(full), .empty(empty), .head_addr(head_addr), .head_data(head_data),
    .rd_ptr(rd_ptr), .ent_vld(ent_vld), .ent_addr(ent_addr), .ent_data(ent_data)
  );

  always_comb begin
    we    = WRITE_DISABLE;
    waddr = '0;
    wdata = '0;
    if (rst && pipe_act) begin
      we    = WRITE_ENABLE;
      waddr = pipe_waddr;
      wdata = pipe_wdata;
    end else if (pop) begin
      we    = WRITE_ENABLE;
      waddr = head_addr;
      wdata = head_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                  starve <= '0;
    else if (pop || empty)                     starve <= '0;
    else if (pipe_act && starve != SW'(STARVE_MAX)) starve <= starve + 1'b1;
  end

  assign stallreq = (starve == SW'(STARVE_MAX));

  // walk oldest to youngest so the youngest match is left standing
  assign lk_addr_v = {lk_addr2, lk_addr1};
  always_comb begin
    lk_hit_v  = '0;
    lk_data_v = '0;
    idx       = '0;
    for (int p = 0; p < 2; p++) begin
      for (int k = 0; k < DEPTH; k++) begin
        idx = rd_ptr + PW'(k);
        if (lk_addr_v[p] != '0 && ent_vld[idx] && ent_addr[idx] == lk_addr_v[p]) begin
          lk_hit_v[p]  = 1'b1;
          lk_data_v[p] = ent_data[idx];
        end
      end
    end
  end

  assign lk_hit1  = lk_hit_v[0];
  assign lk_data1 = lk_data_v[0];
  assign lk_hit2  = lk_hit_v[1];
  assign lk_data2 = lk_data_v[1];
endmodule

// File: doc/wb_write_arbiter.md
Name: wb_write_arbiter

Overview:
- Sole driver of the register file's single write port (we/waddr/wdata).
- Merges two result sources:
  - the in-order MEM/WB pipeline write, which is never back-pressured;
  - late results from the multi-cycle multiply unit, which use a valid/ready handshake.
- Multiply results wait in a small FIFO until the port is free.
- Two lookup ports expose buffered results to ID-stage forwarding; a stall request prevents the FIFO from starving.

Parameters:
- DATA_W, 32, register data width
- ADDR_W, 5, register address width
- DEPTH, 2, multiply-result FIFO entries (power of two, >= 2)
- STARVE_MAX, 4, blocked cycles before stallreq asserts

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous reset, active-low
- pipe_we  input  1  MEM/WB write enable
- pipe_waddr  input  ADDR_W  MEM/WB destination
- pipe_wdata  input  DATA_W  MEM/WB result
- mul_valid  input  1  multiply result offered
- mul_waddr  input  ADDR_W  multiply destination
- mul_wdata  input  DATA_W  multiply result
- mul_ready  output  1  FIFO can accept
- we  output  1  regfile write enable
- waddr  output  ADDR_W  regfile write address
- wdata  output  DATA_W  regfile write data
- lk_addr1  input  ADDR_W  forwarding lookup address 1
- lk_hit1  output  1  lookup 1 matches buffered entry
- lk_data1  output  DATA_W  lookup 1 data
- lk_addr2  input  ADDR_W  forwarding lookup address 2
- lk_hit2  output  1  lookup 2 matches buffered entry
- lk_data2  output  DATA_W  lookup 2 data
- stallreq  output  1  request to ctrl to insert a pipeline bubble

Behaviour:
- Reset (rst=0, asynchronous):
  - FIFO empty; pointers, count and starve counter cleared.
  - All outputs 0, including mul_ready=0.
  - Entry contents are don't-care.
- Pipe write is "active" when pipe_we=1 and pipe_waddr!=0.
- Write port (combinational, zero latency):
  - If pipe write active: we=1, waddr/wdata = pipe values.
  - Else if FIFO non-empty: we=1, waddr/wdata = FIFO head, and the head is popped at the clock edge.
  - Else: we=0, waddr=0, wdata=0.
- pipe_we=1 with pipe_waddr=0 is treated as no write, and the FIFO may drain that cycle.
- Enqueue:
  - mul_ready = !full. The value is computed from state before any same-cycle pop, so a full FIFO does not accept even while popping.
  - Handshake fires when mul_valid & mul_ready.
  - mul_waddr=0: handshake completes, entry is discarded, not enqueued.
  - No fall-through: an entry enqueued at edge N can reach the port at the earliest in the cycle after edge N.
- Simultaneous push and pop on a non-full FIFO: count unchanged, both pointers advance, wrap modulo DEPTH.
- Starve counter:
  - Increments each cycle the FIFO is non-empty and a pipe write is active; saturates at STARVE_MAX.
  - Clears on any pop or when empty.
- stallreq = (starve counter == STARVE_MAX).
- ctrl contract: pipe write inactive from the cycle after stallreq rises until the next pop. The block does not enforce this.
- Lookups (combinational):
  - Hit when any valid FIFO entry matches a non-zero lk_addr; addr 0 never hits.
  - Multiple matches: youngest entry wins.
  - No hit: lk_data=0.
  - The entry being popped this cycle still hits; regfile write bypass covers the same cycle too.
- WAW ordering between sources is guaranteed by ID issue interlock and is not checked here.
- Reset asserted mid-operation drops all buffered entries immediately; no partial write occurs after rst falls.

Decomposition:
- Shared defines header:
  - ZeroWord, RegBus, RegAddrBus, WriteEnable/WriteDisable;
  - a new define MulFifoDepth;
  - the starve threshold.
- One sub-module is natural: wb_result_fifo.
  - Parameterised sync FIFO with async active-low reset.
  - Exposes a per-entry valid/addr/data view for the lookup logic.
  - Arbitration, starve counter and lookup muxing stay in the top.

Test Plan:
- Reset then idle: rst=0 mid-cycle -> we=0, mul_ready=0, stallreq=0 immediately. rst=1 -> mul_ready=1, we=0.
- Pipe-only: pipe_we=1, addr=5, data=0x1234 -> same cycle we=1, waddr=5, wdata=0x1234. pipe_waddr=0 -> we=0.
- Drain: mul push (addr=7, 0xAAAA) with pipe idle -> we=0 that cycle; next cycle we=1, waddr=7, wdata=0xAAAA; FIFO empty after.
- Full/priority:
  - Push 2 entries (r3=0x3, r4=0x4) while pipe writes continuously -> mul_ready=0 after the 2nd push.
  - stallreq=1 after 4 blocked cycles.
  - Pipe released -> r3 then r4 written on consecutive cycles, stallreq=0 after the first pop.
  - Full-state push attempt is not accepted.
- Lookup: buffer r9=0x11 then r9=0x22 -> lk_addr1=9 gives hit=1, data=0x22; lk_addr2=0 gives hit=0; after both pops, hit=0.
- Edge: mul_waddr=0 handshake -> accepted, nothing written. Async reset with 2 buffered entries -> no writes after release, mul_ready=1.
